// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed multiply (radix-2 Booth) and, when the
// macro MUL_DIV_UNIT_DIV_EN is defined, signed restoring divide.
// One bit is processed per clock and WIDTH iterations complete an operation.
// The results are registered separately from the working accumulator, so
// z_hi, z_lo and div_by_zero hold the last completed result while the next
// operation is still iterating.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] bus_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc_hi, hi_nx;
  logic [WIDTH-1:0] acc_lo, lo_nx;
  logic [WIDTH-1:0] mcand;
  logic             q1, q1_nx;
  logic [WIDTH:0]   m_ext, sum;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             accept, dz, last;

`ifdef MUL_DIV_UNIT_DIV_EN
  logic             op_q, neg_q, neg_r;
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] y_mag, b_mag;

  assign accept = start && (state == IDLE);
  assign dz     = op && (bus_in == '0);
  assign y_mag  = y_in[WIDTH-1]   ? ('0 - y_in)   : y_in;
  assign b_mag  = bus_in[WIDTH-1] ? ('0 - bus_in) : bus_in;
`else
  assign accept = start && (state == IDLE) && !op;
  assign dz     = 1'b0;
`endif

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; a divide by zero bypasses RUN entirely
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = dz ? DONE : RUN;
      RUN:  if (last)   state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One iteration step plus the final, sign-corrected result of that step
  always_comb begin
    m_ext = {mcand[WIDTH-1], mcand};
    unique case ({acc_lo[0], q1})
      2'b01:   sum = acc_hi + m_ext;
      2'b10:   sum = acc_hi - m_ext;
      default: sum = acc_hi;
    endcase
    hi_nx  = {sum[WIDTH], sum[WIDTH:1]};
    lo_nx  = {sum[0], acc_lo[WIDTH-1:1]};
    q1_nx  = acc_lo[0];
    res_hi = hi_nx[WIDTH-1:0];
    res_lo = lo_nx;
`ifdef MUL_DIV_UNIT_DIV_EN
    sh    = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    trial = {1'b0, sh} - {2'b00, mcand};
    if (op_q) begin
      if (!trial[WIDTH+1]) begin
        hi_nx = trial[WIDTH:0];
        lo_nx = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = sh;
        lo_nx = {acc_lo[WIDTH-2:0], 1'b0};
      end
      q1_nx  = 1'b0;
      res_lo = neg_q ? ('0 - lo_nx) : lo_nx;
      res_hi = neg_r ? ('0 - hi_nx[WIDTH-1:0]) : hi_nx[WIDTH-1:0];
    end
`endif
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      mcand       <= '0;
      q1          <= 1'b0;
      z_hi        <= '0;
      z_lo        <= '0;
      div_by_zero <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
      op_q        <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else if (accept) begin
      cnt    <= '0;
      acc_hi <= '0;
      q1     <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
      op_q   <= op;
      if (op) begin
        if (dz) begin
          z_hi        <= y_in;
          z_lo        <= '1;
          div_by_zero <= 1'b1;
        end
        mcand  <= b_mag;
        acc_lo <= y_mag;
        neg_q  <= y_in[WIDTH-1] ^ bus_in[WIDTH-1];
        neg_r  <= y_in[WIDTH-1];
      end else begin
        mcand  <= y_in;
        acc_lo <= bus_in;
      end
`else
      mcand  <= y_in;
      acc_lo <= bus_in;
`endif
    end else if (state == RUN) begin
      acc_hi <= hi_nx;
      acc_lo <= lo_nx;
      q1     <= q1_nx;
      cnt    <= cnt + 1'b1;
      if (last) begin
        z_hi        <= res_hi;
        z_lo        <= res_lo;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the stimulus process pushes reference
// results (from plain 64-bit arithmetic) into a queue; a negedge monitor
// compares them whenever done is seen and checks that results hold between
// operations. Divide coverage follows MUL_DIV_UNIT_DIV_EN.
module tb_mul_div_unit;

  localparam int W = 32;

`ifdef MUL_DIV_UNIT_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          acc;
    int          lat_min;
    int          lat_max;
    int          busy_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] y_in = '0;
  logic [31:0] bus_in = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] z_hi, z_lo;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vec = 0;
  int   misc = 0;
  int   rd = 0;
  int   bcnt = 0;
  int   drain = 0;
  int   stim_timeouts = 0;
  bit   stim_done = 1'b0;
  logic [31:0] hold_hi = '0, hold_lo = '0;
  logic        hold_dbz = 1'b0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .y_in(y_in), .bus_in(bus_in),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .z_hi(z_hi), .z_lo(z_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                 input int acc);
    exp_t   e;
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.acc = acc;
    e.dbz = 1'b0;
    e.lat_min = W + 1;
    e.lat_max = W + 1;
    e.busy_n = W;
    if (!o) begin
      p = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.hi = a;
      e.lo = '1;
      e.dbz = 1'b1;
      e.lat_min = 1;
      e.lat_max = 2;
      e.busy_n = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vec++;
    if (act !== expv) begin
      misc++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic summary();
    chk("stim_timeouts", 64'(stim_timeouts), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
    $finish;
  endtask

  // Monitor: reset checks, result compare on done, hold checks otherwise
  always @(negedge clk) begin
    if (cyc > 20000) begin
      misc++;
      $display("FAIL watchdog: got cycle %0d, expected completion before 20000", cyc);
      summary();
    end
    if (clr) begin
      rd = exp_q.size();
      bcnt = 0;
      hold_hi = '0;
      hold_lo = '0;
      hold_dbz = 1'b0;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_dbz", 64'(div_by_zero), 64'd0);
      chk("reset_z_hi", 64'(z_hi), 64'd0);
      chk("reset_z_lo", 64'(z_lo), 64'd0);
    end else begin
      if (busy) bcnt++;
      if (rd == exp_q.size() && (busy || done)) begin
        vec++;
        misc++;
        $display("FAIL spurious_activity: got busy=%b done=%b, expected both 0", busy, done);
      end
      if (done && rd < exp_q.size()) begin
        exp_t e;
        int   lat;
        e = exp_q[rd];
        rd++;
        lat = cyc - e.acc + 1;
        chk("z_hi", 64'(z_hi), 64'(e.hi));
        chk("z_lo", 64'(z_lo), 64'(e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        chk("busy_cycles", 64'(bcnt), 64'(e.busy_n));
        vec++;
        if (lat < e.lat_min || lat > e.lat_max) begin
          misc++;
          $display("FAIL done_latency: got %0d, expected %0d..%0d", lat, e.lat_min, e.lat_max);
        end
        hold_hi = e.hi;
        hold_lo = e.lo;
        hold_dbz = e.dbz;
        bcnt = 0;
      end else if (!done) begin
        chk("hold_z_hi", 64'(z_hi), 64'(hold_hi));
        chk("hold_z_lo", 64'(z_lo), 64'(hold_lo));
        chk("hold_dbz", 64'(div_by_zero), 64'(hold_dbz));
      end
      if (stim_done) begin
        drain++;
        if (rd == exp_q.size() && !busy && !done) summary();
        else if (drain > 200) begin
          misc++;
          $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size() - rd);
          summary();
        end
      end
    end
  end

  // Waits (bounded) for IDLE, then presents one accepted request
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || done) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) stim_timeouts++;
    start = 1'b1;
    op = o;
    y_in = a;
    bus_in = b;
    exp_q.push_back(model(o, a, b, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    y_in = $urandom;
    bus_in = $urandom;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    clr = 1'b0;

    issue(1'b0, 32'd3, 32'hFFFF_FFFB);
    issue(1'b0, 32'h8000_0000, 32'h8000_0000);
    issue(1'b0, 32'h7FFF_FFFF, 32'h8000_0000);

    if (DIV_EN) begin
      issue(1'b1, 32'hFFFF_FFEF, 32'd5);
      issue(1'b1, 32'h0000_0064, 32'd0);
      issue(1'b0, 32'd7, 32'd6);
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(1'b1, 32'd17, 32'hFFFF_FFFB);
      issue(1'b1, 32'd3, 32'd10);
    end else begin
      // divide request must be ignored: monitor flags any busy/done, hold checks cover outputs
      @(negedge clk);
      start = 1'b1;
      op = 1'b1;
      y_in = 32'h64;
      bus_in = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
    end

    // start while busy at N+5 must be ignored
    issue(1'b0, 32'h1234_5678, 32'h0000_0ABC);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op = 1'b0;
    y_in = 32'hDEAD_BEEF;
    bus_in = 32'h0000_0002;
    @(negedge clk);
    start = 1'b0;

    // clr at N+10 aborts the operation without a done pulse
    issue(1'b0, 32'hFFFF_0001, 32'h0001_FFFF);
    repeat (9) @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    issue(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFD);

    for (int i = 0; i < 24; i++) begin
      logic o;
      o = DIV_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      issue(o, pick(), pick());
    end

    stim_done = 1'b1;
  end

endmodule
